// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter: data width, buffer depth,
// starvation limit and the per-cycle source selection encoding.
package wb_arbiter_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int DEPTH_DEF      = 2;
  localparam int STARVE_LIM_DEF = 4;
  localparam int RD_W           = 5;

  // Which source loads the regfile write register this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_BUF  = 2'd2,
    SRC_BYP  = 2'd3
  } wb_src_e;

  // A request only produces a write when valid and not aimed at x0.
  function automatic logic rd_live(input logic valid, input logic [RD_W-1:0] rd);
    return valid && (rd != '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending {rd, data} writebacks for the slow source.
// Exposes every slot's rd plus a liveness mask so the top can answer hazard queries.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [RD_W-1:0]       push_rd,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  output logic [RD_W-1:0]       head_rd,
  output logic [XLEN-1:0]       head_data,
  output logic [CNT_W-1:0]      count,
  output logic [DEPTH*RD_W-1:0] entry_rd,
  output logic [DEPTH-1:0]      entry_valid
);

  logic [RD_W-1:0]  rd_mem   [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A slot is live when its distance from head (mod DEPTH) is below count.
  function automatic logic slot_live(input int slot, input int head, input int cnt);
    int off;
    off = (slot >= head) ? (slot - head) : (slot + DEPTH - head);
    return off < cnt;
  endfunction

  always_comb begin
    head_next  = pop  ? ptr_inc(head_reg) : head_reg;
    tail_next  = push ? ptr_inc(tail_reg) : tail_reg;
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Storage carries no reset: liveness comes solely from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_reg]   <= push_rd;
      data_mem[tail_reg] <= push_data;
    end
  end

  assign head_rd   = rd_mem[head_reg];
  assign head_data = data_mem[head_reg];
  assign count     = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_rd[gi*RD_W +: RD_W] = rd_mem[gi];
      assign entry_valid[gi]           = slot_live(gi, int'(head_reg), int'(count_reg));
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter.sv
// Merges the ALU writeback stream with a buffered slow-source stream into one
// registered regfile write port, with starvation relief and pending-write queries.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      q_addr1,
  input  logic [4:0]      q_addr2,
  output logic            q_hit1,
  output logic            q_hit2
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIM + 1);

  logic [CNT_W-1:0]      count;
  logic [RD_W-1:0]       head_rd;
  logic [XLEN-1:0]       head_data;
  logic [DEPTH*RD_W-1:0] entry_rd;
  logic [DEPTH-1:0]      entry_valid;

  logic                  alu_win;
  logic                  mem_fire;
  logic                  mem_live;
  logic                  buf_push;
  logic                  buf_pop;
  wb_src_e               src_sel;

  logic [SC_W-1:0]       starve_reg, starve_next;
  logic                  rf_we_next;
  logic [4:0]            rf_waddr_next;
  logic [XLEN-1:0]       rf_wdata_next;

  wb_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (buf_push),
    .push_rd     (mem_rd),
    .push_data   (mem_data),
    .pop         (buf_pop),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .count       (count),
    .entry_rd    (entry_rd),
    .entry_valid (entry_valid)
  );

  // Ready depends on the registered count only, so a pop never opens ready the same cycle.
  assign mem_ready = (count < CNT_W'(DEPTH));
  assign alu_stall = (starve_reg == SC_W'(STARVE_LIM)) && (count != '0);

  always_comb begin
    alu_win  = rd_live(alu_valid, alu_rd);
    mem_fire = mem_valid && mem_ready;
    mem_live = rd_live(mem_fire, mem_rd);

    src_sel = SRC_NONE;
    if (alu_win)
      src_sel = SRC_ALU;
    else if (count != '0)
      src_sel = SRC_BUF;
    else if (mem_live)
      src_sel = SRC_BYP;

    buf_pop  = (src_sel == SRC_BUF);
    buf_push = mem_live && (src_sel != SRC_BYP);

    rf_we_next    = (src_sel != SRC_NONE);
    rf_waddr_next = rf_waddr;
    rf_wdata_next = rf_wdata;
    case (src_sel)
      SRC_ALU: begin
        rf_waddr_next = alu_rd;
        rf_wdata_next = alu_data;
      end
      SRC_BUF: begin
        rf_waddr_next = head_rd;
        rf_wdata_next = head_data;
      end
      SRC_BYP: begin
        rf_waddr_next = mem_rd;
        rf_wdata_next = mem_data;
      end
      default: ;
    endcase

    // Only ALU wins over a non-empty buffer count toward starvation.
    starve_next = '0;
    if (alu_win && (count != '0))
      starve_next = (starve_reg == SC_W'(STARVE_LIM)) ? starve_reg : starve_reg + SC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      starve_reg <= '0;
    end else begin
      rf_we      <= rf_we_next;
      rf_waddr   <= rf_waddr_next;
      rf_wdata   <= rf_wdata_next;
      starve_reg <= starve_next;
    end
  end

  logic [DEPTH-1:0] buf_hit1;
  logic [DEPTH-1:0] buf_hit2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign buf_hit1[gi] = entry_valid[gi] && (entry_rd[gi*RD_W +: RD_W] == q_addr1);
      assign buf_hit2[gi] = entry_valid[gi] && (entry_rd[gi*RD_W +: RD_W] == q_addr2);
    end
  endgenerate

  assign q_hit1 = (q_addr1 != '0) && ((rf_we && (rf_waddr == q_addr1)) || (|buf_hit1));
  assign q_hit2 = (q_addr2 != '0) && ((rf_we && (rf_waddr == q_addr2)) || (|buf_hit2));

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default `XLEN from defines.v: data width.
REQ-002 Parameter DEPTH, default 2: slow-source buffer entries.
REQ-003 Parameter STARVE_LIM, default 4: consecutive ALU wins before forced drain.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 alu_valid  input  1  ALU-pipe writeback request; no backpressure.
REQ-007 alu_rd  input  5  ALU destination register.
REQ-008 alu_data  input  XLEN  ALU result.
REQ-009 alu_stall  output  1  upstream must hold alu_valid low this cycle.
REQ-010 mem_valid  input  1  load/multicycle-unit writeback request.
REQ-011 mem_ready  output  1  buffer accepts mem request this cycle.
REQ-012 mem_rd  input  5  mem destination register.
REQ-013 mem_data  input  XLEN  mem result.
REQ-014 rf_we  output  1  regfile write enable, registered.
REQ-015 rf_waddr  output  5  regfile write address, registered.
REQ-016 rf_wdata  output  XLEN  regfile write data, registered.
REQ-017 q_addr1, q_addr2  input  5 each  decode-stage source register queries.
REQ-018 q_hit1, q_hit2  output  1 each  queried register has a pending, not-yet-committed write.

Function
REQ-019 Mem handshake: transfer when mem_valid && mem_ready; mem_ready = (count < DEPTH), computed from registered count only, no same-cycle pop-to-ready path.
REQ-020 Accepted mem request with mem_rd==0 is consumed and discarded (never buffered, never written).
REQ-021 alu_valid with alu_rd==0 is ignored (no write, no starvation count).
REQ-022 Per cycle, output register loads exactly one source, priority: ALU (alu_valid, rd!=0) > buffer head (count>0) > bypass (count==0, accepted mem, rd!=0).
REQ-023 Bypass: with buffer empty and no ALU write, accepted mem request loads output register directly; latency handshake-to-rf_we = 1 cycle.
REQ-024 Otherwise accepted mem request (rd!=0) enqueues at tail; buffered latency >= 2 cycles.
REQ-025 Simultaneous push and pop: count unchanged, FIFO order preserved.
REQ-026 Mem writes commit in acceptance order; no mem write is ever lost or duplicated.
REQ-027 rf_we=1 only in the cycle after a source was selected; rf_we=0 otherwise; rf_waddr/rf_wdata hold last values when rf_we=0.
REQ-028 Starvation counter: increments (saturating at STARVE_LIM) each cycle ALU wins while count>0; clears when buffer pops or count==0.
REQ-029 alu_stall = (starve_cnt==STARVE_LIM) && (count>0), combinational from registers.
REQ-030 If alu_valid is asserted despite alu_stall, ALU still wins (no data loss); counter stays saturated.
REQ-031 q_hitN = 1 iff q_addrN!=0 and matches rf_waddr with rf_we=1 or any valid buffer entry rd; combinational.

Reset
REQ-032 rst synchronous, active-high, dominates all other inputs on the same edge.
REQ-033 Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, count=0, head/tail=0, starve_cnt=0; thus mem_ready=1, alu_stall=0, q_hit1=q_hit2=0 in the cycle after reset.
REQ-034 Reset mid-operation discards buffered entries without writing them; a handshake in the reset cycle is dropped.

Structure
REQ-035 XLEN comes from defines.v; STARVE_LIM and DEPTH defaults are defined there as shared constants.
REQ-036 Buffer is one sub-module wb_fifo (DEPTH entries of {rd, data}, push/pop/count, per-entry rd exposed for hit compare).
REQ-037 rf_* ports connect directly to the regfile write port (we/waddr/wdata).

Verification
REQ-038 Bypass: idle, mem_valid rd=5 data=0x12345678 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678.
REQ-039 Collision: alu_valid rd=3 data=0xA plus mem rd=4 data=0xB same cycle -> rf writes x3=0xA then x4=0xB on consecutive cycles.
REQ-040 Full: ALU valid every cycle, 3 mem requests -> mem_ready=0 after two accepted; third held until pop; order preserved.
REQ-041 Starvation: count>0, ALU valid continuously -> alu_stall=1 after 4 ALU wins; upstream drops alu_valid; buffer head written; alu_stall=0 next.
REQ-042 x0 and hits: mem rd=0 accepted, no write; pending rd=7 with q_addr1=7 -> q_hit1=1 until commit cycle passes.
REQ-043 Reset: rst with 2 entries buffered -> no rf_we afterwards, mem_ready=1, q_hit=0.
